// File: rtl/quadgen_pkg.sv
// -----------------------------------------------------------------------------
// quadgen_pkg
// Shared definitions for the quadrature encoder generator:
//   - generator state encoding (IDLE, RUN)
//   - the four Gray-coded quadrature phases in forward order
//   - encodings of the one-cycle up/down pulse pair
//   - gray_of(): phase index (0..3) to {A,B} lookup
// -----------------------------------------------------------------------------
package quadgen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Forward sequence 00 -> 01 -> 11 -> 10 -> 00; reverse walks it backwards.
  localparam logic [1:0] GRAY_0 = 2'b00;
  localparam logic [1:0] GRAY_1 = 2'b01;
  localparam logic [1:0] GRAY_2 = 2'b11;
  localparam logic [1:0] GRAY_3 = 2'b10;

  localparam logic [1:0] UPDOWN_UP   = 2'b10;
  localparam logic [1:0] UPDOWN_DOWN = 2'b01;
  localparam logic [1:0] UPDOWN_NONE = 2'b00;

  // Map a phase index to its quadrature pattern.
  function automatic logic [1:0] gray_of(input logic [1:0] phase);
    logic [1:0] code;
    case (phase)
      2'd0:    code = GRAY_0;
      2'd1:    code = GRAY_1;
      2'd2:    code = GRAY_2;
      2'd3:    code = GRAY_3;
      default: code = GRAY_0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/quadgen_step_timer.sv
// -----------------------------------------------------------------------------
// quadgen_step_timer
// Loadable down-counter that paces quadrature edges.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous reset, active high
//   load    in   load the counter with period (wins over en)
//   en      in   count down one per clock
//   period  in   reload value (caller guarantees >= 1)
//   expire  out  counter is at 1 while enabled: this clock is an edge clock
// With period P loaded at edge t, expire is seen at edges t+P, t+2P, ...
// as long as the caller reloads on every expire.
// -----------------------------------------------------------------------------
module quadgen_step_timer #(
  parameter int PERIOD_W = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  output logic                expire
);

  logic [PERIOD_W-1:0] count_r;

  assign expire = en && (count_r == PERIOD_W'(1));

  // Counter register: load has priority, otherwise count down to zero and stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {PERIOD_W{1'b0}};
    end else if (load) begin
      count_r <= period;
    end else if (en && (count_r != {PERIOD_W{1'b0}})) begin
      count_r <= count_r - PERIOD_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/quad_encoder_gen.sv
// -----------------------------------------------------------------------------
// quad_encoder_gen
// Quadrature encoder emulator. Accepts signed step commands and emits A/B
// Gray-coded quadrature at a programmable edge rate, plus the matching
// one-cycle up/down pulse pair for driving an up/down counter directly.
//
// Ports:
//   clk         in   system clock, posedge
//   rst         in   synchronous reset, active high
//   cmd_valid   in   command present
//   cmd_ready   out  idle and able to accept a command
//   cmd_steps   in   signed step count (sign = direction, |value| = edges)
//   cmd_period  in   clocks between edges (0 behaves as 1)
//   abort       in   stop the running command immediately
//   q           out  quadrature {A,B}
//   updown      out  2'b10 up / 2'b01 down pulse on each edge, else 2'b00
//   pos         out  net edges since reset, modulo 2^SIZE
//   done        out  one-cycle pulse on completion or abort
//   index       out  index channel
//
// Optional feature, macro QUAD_ENCODER_GEN_INDEX_EN: an index counter modulo
// CPR follows every edge and index is high while it is zero. Without the
// macro index is tied low and no counter exists.
// All outputs are registered.
// -----------------------------------------------------------------------------
module quad_encoder_gen
  import quadgen_pkg::*;
#(
  parameter int SIZE     = 8,
  parameter int STEPS_W  = 16,
  parameter int PERIOD_W = 12,
  parameter int CPR      = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [STEPS_W-1:0]  cmd_steps,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                abort,
  output logic [1:0]          q,
  output logic [1:0]          updown,
  output logic [SIZE-1:0]     pos,
  output logic                done,
  output logic                index
);

  if (CPR < 4) begin : g_cpr_range
    $error("quad_encoder_gen: CPR must be at least 4");
  end

  state_t              state_r, state_next;
  logic                dir_r, dir_next;          // 1 = reverse
  logic [STEPS_W-1:0]  remaining_r, remaining_next;
  logic [PERIOD_W-1:0] period_r, period_next;
  logic [1:0]          phase_r, phase_next;
  logic [1:0]          q_r, updown_r, updown_next;
  logic [SIZE-1:0]     pos_r, pos_next;
  logic                done_r, done_next;
  logic                ready_r, ready_next;

  logic                accept_s;
  logic [STEPS_W-1:0]  mag_s;
  logic [PERIOD_W-1:0] period_eff_s;
  logic                expire_s;
  logic                step_s;
  logic                timer_load_s;
  logic [PERIOD_W-1:0] timer_value_s;

  // Command decode: magnitude of a two's-complement value in the same width
  // is exact, including the most negative value (its magnitude is 2^(W-1)).
  always_comb begin
    accept_s = (state_r == IDLE) && ready_r && cmd_valid;
    if (cmd_steps[STEPS_W-1]) begin
      mag_s = (~cmd_steps) + STEPS_W'(1);
    end else begin
      mag_s = cmd_steps;
    end
    if (cmd_period == {PERIOD_W{1'b0}}) begin
      period_eff_s = PERIOD_W'(1);
    end else begin
      period_eff_s = cmd_period;
    end
  end

  // Abort suppresses an edge that would otherwise fire in the same clock.
  assign step_s        = (state_r == RUN) && expire_s && !abort;
  assign timer_load_s  = (accept_s && (mag_s != {STEPS_W{1'b0}})) || step_s;
  assign timer_value_s = accept_s ? period_eff_s : period_r;

  quadgen_step_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load_s),
    .en     (state_r == RUN),
    .period (timer_value_s),
    .expire (expire_s)
  );

  // Next-state and next-output logic for the IDLE/RUN generator.
  always_comb begin
    state_next     = state_r;
    dir_next       = dir_r;
    remaining_next = remaining_r;
    period_next    = period_r;
    phase_next     = phase_r;
    pos_next       = pos_r;
    updown_next    = UPDOWN_NONE;
    done_next      = 1'b0;

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          dir_next    = cmd_steps[STEPS_W-1];
          period_next = period_eff_s;
          if (mag_s == {STEPS_W{1'b0}}) begin
            remaining_next = {STEPS_W{1'b0}};
            done_next      = 1'b1;
          end else begin
            remaining_next = mag_s;
            state_next     = RUN;
          end
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_next     = IDLE;
          remaining_next = {STEPS_W{1'b0}};
          done_next      = 1'b1;
        end else if (step_s) begin
          if (dir_r) begin
            phase_next  = phase_r - 2'd1;
            pos_next    = pos_r - SIZE'(1);
            updown_next = UPDOWN_DOWN;
          end else begin
            phase_next  = phase_r + 2'd1;
            pos_next    = pos_r + SIZE'(1);
            updown_next = UPDOWN_UP;
          end
          remaining_next = remaining_r - STEPS_W'(1);
          if (remaining_r == STEPS_W'(1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = RUN;
          end
        end else begin
          state_next = RUN;
        end
      end
      default: begin
        state_next     = IDLE;
        remaining_next = {STEPS_W{1'b0}};
      end
    endcase

    // Ready only once the done pulse has been seen in IDLE.
    ready_next = (state_next == IDLE) && !done_next;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      dir_r       <= 1'b0;
      remaining_r <= {STEPS_W{1'b0}};
      period_r    <= PERIOD_W'(1);
      phase_r     <= 2'd0;
      q_r         <= GRAY_0;
      updown_r    <= UPDOWN_NONE;
      pos_r       <= {SIZE{1'b0}};
      done_r      <= 1'b0;
      ready_r     <= 1'b0;
    end else begin
      state_r     <= state_next;
      dir_r       <= dir_next;
      remaining_r <= remaining_next;
      period_r    <= period_next;
      phase_r     <= phase_next;
      q_r         <= gray_of(phase_next);
      updown_r    <= updown_next;
      pos_r       <= pos_next;
      done_r      <= done_next;
      ready_r     <= ready_next;
    end
  end

  assign q         = q_r;
  assign updown    = updown_r;
  assign pos       = pos_r;
  assign done      = done_r;
  assign cmd_ready = ready_r;

`ifdef QUAD_ENCODER_GEN_INDEX_EN
  localparam int IDX_W = $clog2(CPR);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CPR - 1);

  logic [IDX_W-1:0] idx_r, idx_next;
  logic             index_r;

  // Index position modulo CPR, following each emitted edge.
  always_comb begin
    idx_next = idx_r;
    if (step_s) begin
      if (dir_r) begin
        if (idx_r == {IDX_W{1'b0}}) begin
          idx_next = IDX_LAST;
        end else begin
          idx_next = idx_r - IDX_W'(1);
        end
      end else begin
        if (idx_r == IDX_LAST) begin
          idx_next = {IDX_W{1'b0}};
        end else begin
          idx_next = idx_r + IDX_W'(1);
        end
      end
    end else begin
      idx_next = idx_r;
    end
  end

  // Index registers; index updates in the same clock as q.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r   <= {IDX_W{1'b0}};
      index_r <= 1'b1;
    end else begin
      idx_r   <= idx_next;
      index_r <= (idx_next == {IDX_W{1'b0}});
    end
  end

  assign index = index_r;
`else
  assign index = 1'b0;
`endif

endmodule

// File: tb/tb_quad_encoder_gen.sv
// -----------------------------------------------------------------------------
// tb_quad_encoder_gen
// Directed self-checking bench for quad_encoder_gen with default parameters
// (SIZE=8, STEPS_W=16, PERIOD_W=12). Inputs change and outputs are sampled
// on the falling edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_quad_encoder_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_steps;
  logic [11:0] cmd_period;
  logic        abort;
  logic [1:0]  q;
  logic [1:0]  updown;
  logic [7:0]  pos;
  logic        done;
  logic        index;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  quad_encoder_gen dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_steps  (cmd_steps),
    .cmd_period (cmd_period),
    .abort      (abort),
    .q          (q),
    .updown     (updown),
    .pos        (pos),
    .done       (done),
    .index      (index)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Present a command for exactly one rising edge (the acceptance edge).
  task automatic send(input logic [15:0] steps, input logic [11:0] period);
    cmd_valid  = 1'b1;
    cmd_steps  = steps;
    cmd_period = period;
    tick();
    cmd_valid  = 1'b0;
  endtask

  initial begin
    logic [1:0] fwd5 [5];
    logic [1:0] rev3 [3];
    logic [1:0] fwd3 [3];
    int         e;
    int         cnt;
    int         ups;
    int         downs;
    int         illegal;
    int         guard;
    bit         seen;

    fwd5 = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
    rev3 = '{2'b00, 2'b10, 2'b11};
    fwd3 = '{2'b01, 2'b11, 2'b10};

    rst = 1'b1; cmd_valid = 1'b0; cmd_steps = 16'd0; cmd_period = 12'd0; abort = 1'b0;
    @(negedge clk);
    tick(); tick();

    // Reset state
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_updown", 32'(updown), 32'h0);
    chk("rst_pos", 32'(pos), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ready", 32'(cmd_ready), 32'h0);
    chk("rst_index", 32'(index), 32'h0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", 32'(cmd_ready), 32'h1);

    // +5 steps, period 1: edges on the 5 clocks following acceptance
    send(16'd5, 12'd1);
    chk("t1_ready_low", 32'(cmd_ready), 32'h0);
    chk("t1_q_before", 32'(q), 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t1_q", 32'(q), 32'(fwd5[k]));
      chk("t1_updown", 32'(updown), 32'h2);
      chk("t1_pos", 32'(pos), 32'(k + 1));
      chk("t1_done", 32'(done), (k == 4) ? 32'h1 : 32'h0);
    end
    tick();
    chk("t1_ready_back", 32'(cmd_ready), 32'h1);
    chk("t1_done_clear", 32'(done), 32'h0);
    chk("t1_updown_idle", 32'(updown), 32'h0);

    // -3 steps, period 4 from pos 5: edges at acceptance +4, +8, +12
    send(16'hFFFD, 12'd4);
    e = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if ((k % 4) == 0) begin
        chk("t2_updown_edge", 32'(updown), 32'h1);
        e++;
      end else begin
        chk("t2_updown_gap", 32'(updown), 32'h0);
      end
      chk("t2_q", 32'(q), (e == 0) ? 32'h1 : 32'(rev3[e-1]));
      chk("t2_done", 32'(done), (k == 12) ? 32'h1 : 32'h0);
    end
    chk("t2_pos", 32'(pos), 32'd2);
    tick();
    chk("t2_ready_back", 32'(cmd_ready), 32'h1);

    // Reset in the middle of a run returns everything to reset values
    send(16'd10, 12'd1);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("rr_q", 32'(q), 32'h0);
    chk("rr_pos", 32'(pos), 32'h0);
    chk("rr_ready", 32'(cmd_ready), 32'h0);
    chk("rr_updown", 32'(updown), 32'h0);
    rst = 1'b0;
    tick();
    tick();
    chk("rr_still_idle", 32'(q), 32'h0);
    chk("rr_ready_back", 32'(cmd_ready), 32'h1);

    // 300 steps, period 0: a model up/down counter follows updown every clock
    send(16'd300, 12'd0);
    cnt = 0; ups = 0; guard = 0; seen = 1'b0;
    while (!seen && guard < 400) begin
      tick();
      guard++;
      if (updown == 2'b10) begin cnt = (cnt + 1) % 256; ups++; end
      else if (updown == 2'b01) cnt = (cnt + 255) % 256;
      chk("t3_pos_vs_counter", 32'(pos), 32'(cnt));
      seen = done;
    end
    chk("t3_done_seen", 32'(seen), 32'h1);
    chk("t3_edges", 32'(ups), 32'd300);
    chk("t3_pos", 32'(pos), 32'd44);
    chk("t3_q", 32'(q), 32'h0);
    tick();

    // 10 steps, period 2, abort on the clock of the 4th expiry
    send(16'd10, 12'd2);
    e = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if ((k % 2) == 0) e++;
      chk("t4_q", 32'(q), (e == 0) ? 32'h0 : 32'(fwd3[e-1]));
      chk("t4_updown", 32'(updown), ((k % 2) == 0) ? 32'h2 : 32'h0);
    end
    abort = 1'b1;
    tick();
    chk("t4_abort_q_hold", 32'(q), 32'h2);
    chk("t4_abort_pos", 32'(pos), 32'd47);
    chk("t4_abort_no_edge", 32'(updown), 32'h0);
    chk("t4_abort_done", 32'(done), 32'h1);
    chk("t4_abort_ready", 32'(cmd_ready), 32'h0);
    tick();
    chk("t4_ready_back", 32'(cmd_ready), 32'h1);
    chk("t4_done_clear", 32'(done), 32'h0);
    // abort still high in IDLE: the new command is accepted anyway
    send(16'hFFFF, 12'd1);
    abort = 1'b0;
    chk("t4_new_accepted", 32'(cmd_ready), 32'h0);
    tick();
    chk("t4_new_q", 32'(q), 32'h3);
    chk("t4_new_updown", 32'(updown), 32'h1);
    chk("t4_new_pos", 32'(pos), 32'd46);
    chk("t4_new_done", 32'(done), 32'h1);
    tick();

    // Zero steps: no edge, done right after acceptance, ready one clock later
    send(16'd0, 12'd7);
    chk("t5_done", 32'(done), 32'h1);
    chk("t5_ready_low", 32'(cmd_ready), 32'h0);
    chk("t5_q", 32'(q), 32'h3);
    tick();
    chk("t5_done_clear", 32'(done), 32'h0);
    chk("t5_ready_back", 32'(cmd_ready), 32'h1);
    chk("t5_pos", 32'(pos), 32'd46);

    // Most negative command: 32768 down edges, no overflow of the magnitude
    send(16'h8000, 12'd1);
    downs = 0; illegal = 0; guard = 0; seen = 1'b0;
    while (!seen && guard < 33000) begin
      tick();
      guard++;
      if (updown == 2'b01) downs++;
      else if (updown != 2'b00) illegal++;
      if (index != 1'b0) illegal++;
      seen = done;
    end
    chk("t6_done_seen", 32'(seen), 32'h1);
    chk("t6_down_edges", 32'(downs), 32'd32768);
    chk("t6_no_illegal", 32'(illegal), 32'd0);
    chk("t6_pos", 32'(pos), 32'd46);
    chk("t6_q", 32'(q), 32'h3);
    chk("t6_index", 32'(index), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
